// File: rtl/bn_feeder.sv
// Batch-norm feeder: streams NUM_ELEM feature words to the normalizer one at a time
// and writes each result back. Optional macro BN_FEEDER_ADDR_CHECK_EN checks the echoed channel.
module bn_feeder #(
  parameter int NUM_CH   = 20,
  parameter int NUM_ELEM = 50,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_rd_en,
  output logic [5:0]  mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        bn_en,
  output logic [31:0] bn_data,
  output logic [4:0]  bn_addr,
  input  logic        bn_valid_in,
  input  logic [31:0] bn_result_in,
  input  logic [4:0]  bn_result_addr,
  output logic        res_wr_en,
  output logic [5:0]  res_wr_addr,
  output logic [31:0] res_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_WRITE, S_FINISH
  } state_e;

  localparam logic [5:0] LAST_ELEM  = 6'(NUM_ELEM - 1);
  localparam logic [4:0] LAST_CH    = 5'(NUM_CH - 1);
  localparam logic [4:0] TIMER_LAST = 5'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [5:0]  elem_q, elem_d;
  logic [4:0]  ch_q, ch_d;
  logic [4:0]  timer_q, timer_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        rd_en_q, rd_en_d, bn_en_q, bn_en_d, wr_en_q, wr_en_d;
  logic [5:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [31:0] bn_data_q, bn_data_d, wr_data_q, wr_data_d;
  logic [4:0]  bn_addr_q, bn_addr_d;
  logic        addr_ok;

`ifdef BN_FEEDER_ADDR_CHECK_EN
  assign addr_ok = (bn_result_addr == ch_q);
`else
  logic unused_result_addr;
  assign unused_result_addr = ^bn_result_addr;
  assign addr_ok = 1'b1;
`endif

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    ch_d      = ch_q;
    timer_d   = timer_q;
    error_d   = error_q;
    bn_data_d = bn_data_q;
    bn_addr_d = bn_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          error_d = 1'b0;
          elem_d  = '0;
          ch_d    = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        bn_data_d = mem_rd_data;
        bn_addr_d = ch_q;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (bn_valid_in) begin
          if (addr_ok) begin
            wr_addr_d = elem_q;
            wr_data_d = bn_result_in;
            state_d   = S_WRITE;
          end else begin
            error_d = 1'b1;
            state_d = S_FINISH;
          end
        end else if (timer_q == TIMER_LAST) begin
          // This cycle is the TIMEOUT-th without a result.
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_q + 5'd1;
        end
      end
      S_WRITE: begin
        if (elem_q == LAST_ELEM) begin
          state_d = S_FINISH;
        end else begin
          elem_d  = elem_q + 6'd1;
          ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + 5'd1;
          state_d = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH);
    rd_en_d   = (state_d == S_FETCH);
    rd_addr_d = (state_d == S_FETCH) ? elem_d : rd_addr_q;
    bn_en_d   = (state_d == S_WAIT);
    wr_en_d   = (state_d == S_WRITE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      elem_q    <= '0;
      ch_q      <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      bn_en_q   <= 1'b0;
      bn_data_q <= '0;
      bn_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      ch_q      <= ch_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      bn_en_q   <= bn_en_d;
      bn_data_q <= bn_data_d;
      bn_addr_q <= bn_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign bn_en       = bn_en_q;
  assign bn_data     = bn_data_q;
  assign bn_addr     = bn_addr_q;
  assign res_wr_en   = wr_en_q;
  assign res_wr_addr = wr_addr_q;
  assign res_wr_data = wr_data_q;

endmodule

// File: tb/tb_bn_feeder.sv
// Scoreboard bench for bn_feeder: feature buffer and normalizer models drive the DUT,
// expected transfers are queued per run and popped by an independent monitor.
`timescale 1ns/1ps
module tb_bn_feeder;
  localparam int NUM_CH   = 20;
  localparam int NUM_ELEM = 50;
  localparam int TIMEOUT  = 15;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b1;
  logic        busy, done, error, mem_rd_en, bn_en, res_wr_en;
  logic [5:0]  mem_rd_addr, res_wr_addr;
  logic [31:0] mem_rd_data = '0, bn_data, bn_result_in = '0, res_wr_data;
  logic [4:0]  bn_addr, bn_result_addr = '0;
  logic        bn_valid_in = 1'b0;

  always #5 clk = ~clk;

  bn_feeder #(.NUM_CH(NUM_CH), .NUM_ELEM(NUM_ELEM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .bn_en(bn_en), .bn_data(bn_data), .bn_addr(bn_addr),
    .bn_valid_in(bn_valid_in), .bn_result_in(bn_result_in), .bn_result_addr(bn_result_addr),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data));

  typedef struct { logic [5:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [4:0] ch;   logic [31:0] data; } bn_t;

  wr_t         exp_wr[$];
  bn_t         exp_bn[$];
  logic [31:0] mem [64];
  int          errors = 0, checks = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [86:0] all_outs();
    return {busy, done, error, mem_rd_en, mem_rd_addr, bn_en, bn_data, bn_addr,
            res_wr_en, res_wr_addr, res_wr_data};
  endfunction

  // Feature buffer: data appears for exactly the cycle after the read strobe, garbage otherwise.
  logic       rd_pend = 1'b0;
  logic [5:0] rd_pend_addr = '0;
  always @(negedge clk) begin
    mem_rd_data  = rd_pend ? mem[rd_pend_addr] : $urandom;
    rd_pend      = mem_rd_en;
    rd_pend_addr = mem_rd_addr;
  end

  // Normalizer: answers bn_data+offset after a random latency; knobs select faults per run.
  int          m_rise = 0, m_elem = 0, m_cnt = 0, m_lat = 0;
  int          stall_elem = -1, bad_elem = -1, max_lat = 0;
  logic [31:0] offset = 32'd1;
  bit          spurious = 1'b0;
  always @(negedge clk) begin
    bn_valid_in    = 1'b0;
    bn_result_in   = $urandom;
    bn_result_addr = 5'($urandom);
    if (bn_en) begin
      if (m_cnt == 0) begin
        m_elem = m_rise;
        m_rise++;
        m_lat  = $urandom_range(max_lat, 0);
      end
      m_cnt++;
      if (m_cnt > m_lat && m_elem != stall_elem) begin
        bn_valid_in    = 1'b1;
        bn_result_in   = bn_data + offset;
        bn_result_addr = (m_elem == bad_elem) ? 5'd7 : bn_addr;
      end
    end else begin
      m_cnt = 0;
      if (spurious) bn_valid_in = ($urandom_range(3, 0) == 0);
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or a write.
  int          done_cnt = 0, busy_cycles = 0, bn_rise = 0, en_len = 0, last_en_len = 0;
  logic        last_err = 1'b0, en_prev = 1'b0;
  logic [31:0] hold_data = '0, last_en_data = '0;
  logic [4:0]  hold_addr = '0;
  wr_t         w;
  bn_t         b;
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (done) begin
      done_cnt++;
      last_err = error;
    end
    if (res_wr_en) begin
      if (exp_wr.size() == 0) check("write_expected", exp_wr.size(), 1);
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", res_wr_addr, w.addr);
        check("wr_data", res_wr_data, w.data);
      end
    end
    if (bn_en && !en_prev) begin
      bn_rise++;
      en_len    = 1;
      hold_data = bn_data;
      hold_addr = bn_addr;
      if (exp_bn.size() == 0) check("bn_expected", exp_bn.size(), 1);
      else begin
        b = exp_bn.pop_front();
        check("bn_addr", bn_addr, b.ch);
        check("bn_data", bn_data, b.data);
      end
    end else if (bn_en) begin
      en_len++;
      check("bn_hold", {bn_data, bn_addr}, {hold_data, hold_addr});
    end else if (en_prev) begin
      last_en_len  = en_len;
      last_en_data = hold_data;
    end
    en_prev = bn_en;
  end

  task automatic fill_mem(input bit random_data);
    for (int k = 0; k < 64; k++) mem[k] = random_data ? $urandom : (32'(k) << 24);
  endtask

  // Reference model of one run: element k -> channel k mod NUM_CH, result at address k.
  task automatic prepare(input int stall, input int bad, input int lat, input bit spur,
                         input logic [31:0] off);
    stall_elem = stall; bad_elem = bad; max_lat = lat; spurious = spur; offset = off;
    m_rise = 0; busy_cycles = 0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      exp_bn.push_back('{ch: 5'(k % NUM_CH), data: mem[k]});
      if (k == stall) break;
`ifdef BN_FEEDER_ADDR_CHECK_EN
      if (k == bad) break;
`endif
      exp_wr.push_back('{addr: 6'(k), data: mem[k] + off});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    check("busy_before_start", busy, 1'b0);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("error_cleared", error, 1'b0);
  endtask

  task automatic wait_done(input string name, input logic exp_err, input int exp_busy, input int d0);
    for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_error"}, last_err, exp_err);
    check({name, "_busy_now"}, busy, 1'b0);
    check({name, "_writes_left"}, exp_wr.size(), 0);
    check({name, "_reqs_left"}, exp_bn.size(), 0);
    if (exp_busy > 0) check({name, "_busy_cycles"}, busy_cycles, exp_busy);
  endtask

  int  d0, r0;
  logic exp_bad_err;

  initial begin
`ifdef BN_FEEDER_ADDR_CHECK_EN
    exp_bad_err = 1'b1;
`else
    exp_bad_err = 1'b0;
`endif
    #12;
    check("reset_outputs", all_outs(), '0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Run A: word k = k<<24, immediate valid, 4 cycles per element plus FINISH.
    fill_mem(1'b0);
    prepare(-1, -1, 0, 1'b0, 32'd1);
    d0 = done_cnt;
    pulse_start();
    wait_done("run_a", 1'b0, 4 * NUM_ELEM + 1, d0);

    // Run B: random data, latency and stray valids; a start during element 10 is ignored.
    fill_mem(1'b1);
    prepare(-1, -1, 10, 1'b1, $urandom);
    d0 = done_cnt; r0 = bn_rise;
    pulse_start();
    for (int i = 0; i < 2000 && bn_rise - r0 < 11; i++) begin
      @(negedge clk); #1;
    end
    check("b_reached_elem10", bn_rise - r0, 11);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("run_b", 1'b0, 0, d0);

    // Run C: element 3 never answered -> timeout after TIMEOUT cycles of bn_en.
    fill_mem(1'b0);
    prepare(3, -1, 0, 1'b0, 32'd1);
    d0 = done_cnt;
    pulse_start();
    wait_done("run_c", 1'b1, 0, d0);
    check("timeout_en_len", last_en_len, TIMEOUT);
    check("timeout_bn_data", last_en_data, 32'h0300_0000);

    // Run D: asynchronous reset while waiting on element 25.
    fill_mem(1'b1);
    prepare(-1, -1, 3, 1'b0, $urandom);
    d0 = done_cnt; r0 = bn_rise;
    pulse_start();
    for (int i = 0; i < 2000 && bn_rise - r0 < 26; i++) begin
      @(negedge clk); #1;
    end
    check("d_reached_elem25", bn_rise - r0, 26);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_outs(), '0);
    check("d_writes_left", exp_wr.size(), NUM_ELEM - 25);
    repeat (3) @(negedge clk);
    check("d_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    exp_wr.delete();
    exp_bn.delete();

    // Run E: fresh run after the abort starts again from element 0.
    fill_mem(1'b1);
    prepare(-1, -1, 5, 1'b1, $urandom);
    d0 = done_cnt;
    pulse_start();
    wait_done("run_e", 1'b0, 0, d0);

    // Run F: wrong channel echoed on element 5.
    fill_mem(1'b1);
    prepare(-1, 5, 4, 1'b0, $urandom);
    d0 = done_cnt;
    pulse_start();
    wait_done("run_f", exp_bad_err, 0, d0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
